// File: rtl/uart_mmio_slave_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the 2-bit state encoding used by both serial FSMs.
package uart_mmio_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_VALID   = 1;
    localparam int STAT_RX_OVERRUN = 2;
    localparam int STAT_FRAME_ERR  = 3;

endpackage

// File: rtl/uart_mmio_slave_tx_ser.sv
// 8N1 transmitter: IDLE -> START -> DATA(8, LSB first) -> STOP, each state held
// for CLKS_PER_BIT cycles. A start request is only honoured while IDLE.
module uart_tx_ser
    import uart_mmio_slave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of always_ff evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            tx       <= tx_nxt;
        end
    end

    // NOTE: every variable gets a hold default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        tx_nxt    = tx;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (start) begin
                    state_nxt = START;
                    shreg_nxt = data;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                end
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/uart_mmio_slave.sv
// Memory-mapped 8N1 UART target on the data-memory bus (TXDATA/RXDATA/STATUS).
// Define UART_RX_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
module uart_mmio_slave
    import uart_mmio_slave_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addra,
    input  logic [31:0] dina,
    input  logic        wea,
    output logic [31:0] douta,
    output logic        sel,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

    logic tx_busy, wr_tx, wr_status;
    logic clr_valid, clr_overrun, clr_ferr;
    logic rx_valid, rx_overrun, frame_err;
    logic [7:0] rx_byte;
    logic unused_bits;

    assign sel         = (addra[31:4] == BASE_ADDR[31:4]);
    assign wr_tx       = wea && sel && (addra[3:2] == UART_TXDATA);
    assign wr_status   = wea && sel && (addra[3:2] == UART_STATUS);
    assign clr_valid   = wr_status && dina[STAT_RX_VALID];
    assign clr_overrun = wr_status && dina[STAT_RX_OVERRUN];
    assign clr_ferr    = wr_status && dina[STAT_FRAME_ERR];
    assign unused_bits = ^{dina[31:8], dina[STAT_TX_BUSY], addra[1:0]};

    uart_tx_ser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (wr_tx),
        .data  (dina[7:0]),
        .tx    (uart_tx),
        .busy  (tx_busy)
    );

    // RX: two-flop synchronizer plus one delayed copy for falling-edge detect.
    logic rx_meta, rx_sync, rx_prev;
    uart_state_t   rx_state, rx_state_nxt;
    logic [BW-1:0] rx_baud, rx_baud_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_good, rx_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nxt;
            rx_baud  <= rx_baud_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_baud_nxt  = rx_baud + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_good      = 1'b0;
        rx_bad       = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_baud_nxt = '0;
                if (rx_prev && !rx_sync) rx_state_nxt = START;
            end
            START: begin
                if (rx_baud == BAUD_HALF) begin
                    rx_baud_nxt  = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_nxt  = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            STOP: begin
                // Leave at the mid-bit sample so the next start edge is not missed.
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_nxt  = '0;
                    rx_state_nxt = IDLE;
                    rx_good      = rx_sync;
                    rx_bad       = !rx_sync;
                end
            end
        endcase
    end

    // Flag updates: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk) begin
        if (rst)           frame_err <= 1'b0;
        else if (rx_bad)   frame_err <= 1'b1;
        else if (clr_ferr) frame_err <= 1'b0;
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic       full, pop, push;

    assign full = (count == 3'd4);
    assign pop  = clr_valid && (count != 3'd0);
    assign push = rx_good && (!full || pop);

    // NOTE: storage is not reset; count guards every read of a stale entry.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + {1'b0, pop};
            wr_ptr <= wr_ptr + {1'b0, push};
            count  <= count + {2'b0, push} - {2'b0, pop};
            if (rx_good && full && !pop) rx_overrun <= 1'b1;
            else if (clr_overrun)        rx_overrun <= 1'b0;
        end
    end

    assign rx_valid = (count != 3'd0);
    assign rx_byte  = rx_valid ? fifo_mem[rd_ptr] : 8'h00;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_good) rx_byte <= rx_shift;

            if (rx_good)        rx_valid <= 1'b1;
            else if (clr_valid) rx_valid <= 1'b0;

            if (rx_good && rx_valid) rx_overrun <= 1'b1;
            else if (clr_overrun)    rx_overrun <= 1'b0;
        end
    end
`endif

    logic [31:0] status;
    always_comb begin
        status                  = '0;
        status[STAT_TX_BUSY]    = tx_busy;
        status[STAT_RX_VALID]   = rx_valid;
        status[STAT_RX_OVERRUN] = rx_overrun;
        status[STAT_FRAME_ERR]  = frame_err;
    end

    always_comb begin
        douta = '0;
        if (sel) begin
            case (addra[3:2])
                UART_RXDATA: douta = {24'b0, rx_byte};
                UART_STATUS: douta = status;
                default:     douta = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_slave.sv
// Directed bench for uart_mmio_slave at 4 clocks per bit; the FIFO section is
// selected with UART_RX_FIFO_EN, matching the build of the design.
module tb_uart_mmio_slave;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addra, dina, douta;
    logic        wea, sel, uart_rx, uart_tx;

    int total = 0;
    int bad   = 0;

    uart_mmio_slave #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .addra   (addra),
        .dina    (dina),
        .wea     (wea),
        .douta   (douta),
        .sel     (sel),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        wea   = 1'b0;
        addra = BASE + {28'b0, off};
        #1;
        d = douta;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        addra = BASE + {28'b0, off};
        dina  = data;
        wea   = 1'b1;
        tick();
        wea   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
        tick(6);
    endtask

    // Writes b, checks each line bit over its CPB cycles, busy through the frame,
    // busy low afterwards and a quiet line; optionally stores 0x3C mid-frame.
    task automatic tx_frame(input string name, input logic [7:0] b,
                            input logic [9:0] exp_bits, input logic busy_write);
        logic [3:0]  samples;
        logic [31:0] d;
        int          busy_err, idle_low;
        busy_err = 0;
        idle_low = 0;
        wr(4'h0, {24'b0, b});
        for (int bitn = 0; bitn < 10; bitn++) begin
            for (int c = 0; c < CPB; c++) begin
                samples[c] = uart_tx;
                if (busy_write && (bitn * CPB + c) == 8) begin
                    addra = BASE;
                    dina  = 32'h3C;
                    wea   = 1'b1;
                end else begin
                    wea   = 1'b0;
                    addra = BASE + 32'h8;
                    #1;
                    if (douta[0] !== 1'b1) busy_err++;
                end
                tick();
            end
            check($sformatf("%s_bit%0d", name, bitn), {28'b0, samples}, {28'b0, {4{exp_bits[bitn]}}});
        end
        wea = 1'b0;
        check($sformatf("%s_busy_during", name), busy_err, 0);
        rd(4'h8, d);
        check($sformatf("%s_busy_after", name), {31'b0, d[0]}, 32'h0);
        repeat (11 * CPB) begin
            if (uart_tx !== 1'b1) idle_low++;
            tick();
        end
        check($sformatf("%s_idle_after", name), idle_low, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_hold;

        vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0000};
        vecs[1] = '{32'h0000_0104, 1'b1, 32'h0000_005A};
        vecs[2] = '{32'h0000_0108, 1'b1, 32'h0000_0002};
        vecs[3] = '{32'h0000_010C, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h0000_0105, 1'b1, 32'h0000_005A};
        vecs[5] = '{32'h0000_0114, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h0000_0004, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h0000_1104, 1'b0, 32'h0000_0000};

        rst = 1'b1; uart_rx = 1'b1; wea = 1'b0; addra = '0; dina = '0;
        tick(2);
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        rd(4'h8, d); check("reset_status", d, 32'h0);
        rd(4'h4, d); check("reset_rxdata", d, 32'h0);
        rst = 1'b0;
        tick();

        tx_frame("tx_a5", 8'hA5, 10'b11_0100_1010, 1'b1);

        send_byte(8'h5A, 1'b1);
        rd(4'h8, d); check("rx_5a_status", d, 32'h2);
        rd(4'h4, d); check("rx_5a_data", d, 32'h5A);

        for (int i = 0; i < 8; i++) begin
            wea   = 1'b0;
            addra = vecs[i].addr;
            #1;
            check($sformatf("map%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            check($sformatf("map%0d_rd", i), douta, vecs[i].exp_rd);
        end

        wr(4'h8, 32'h2);
        rd(4'h8, d); check("w1c_valid", d, 32'h0);

`ifdef UART_RX_FIFO_EN
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1);
        rd(4'h8, d); check("fifo_full_status", d, 32'h6);
        for (int k = 1; k <= 4; k++) begin
            rd(4'h4, d); check($sformatf("fifo_pop%0d", k), d, k);
            wr(4'h8, 32'h2);
        end
        rd(4'h8, d); check("fifo_empty_status", d, 32'h4);
        exp_hold = 32'h0;
`else
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rd(4'h4, d); check("overrun_data", d, 32'h22);
        rd(4'h8, d); check("overrun_status", d, 32'h6);
        exp_hold = 32'h22;
`endif

        wr(4'h8, 32'hE);
        rd(4'h8, d); check("w1c_all", d, 32'h0);
        send_byte(8'h33, 1'b0);
        rd(4'h8, d); check("frame_err_status", d, 32'h8);
        rd(4'h4, d); check("frame_err_data", d, exp_hold);
        wr(4'h8, 32'h8);

        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        tick(12 * CPB);
        rd(4'h8, d); check("glitch_status", d, 32'h0);
        rd(4'h4, d); check("glitch_data", d, exp_hold);

        wr(4'h0, 32'h0F);
        tick(15);
        rst = 1'b1;
        tick();
        check("midreset_uart_tx", {31'b0, uart_tx}, 32'h1);
        rd(4'h8, d); check("midreset_status", d, 32'h0);
        rst = 1'b0;
        tick();
        tx_frame("tx_0f", 8'h0F, {1'b1, 8'h0F, 1'b0}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
